// File: rtl/spi_bus_arbiter_if.sv
// rtl/spi_bus_arbiter_if.sv - requester and spi_master signal bundle for spi_bus_arbiter
interface spi_bus_arbiter_if #(
    parameter int NUM_CLI = 2
);
    logic [NUM_CLI-1:0]   cli_lock;
    logic [NUM_CLI-1:0]   cli_req;
    logic [8*NUM_CLI-1:0] cli_tx;
    logic [NUM_CLI-1:0]   cli_gnt;
    logic [NUM_CLI-1:0]   cli_done;
    logic [7:0]           cli_rx;
    logic                 timeout;
    logic                 spi_req;
    logic [7:0]           spi_tx;
    logic [7:0]           spi_rx;
    logic                 spi_done;

    // Requesters and the byte-level spi_master, seen from outside the arbiter
    modport master (
        output cli_lock, cli_req, cli_tx, spi_rx, spi_done,
        input  cli_gnt, cli_done, cli_rx, timeout, spi_req, spi_tx
    );

    // The arbiter itself
    modport slave (
        input  cli_lock, cli_req, cli_tx, spi_rx, spi_done,
        output cli_gnt, cli_done, cli_rx, timeout, spi_req, spi_tx
    );
endinterface

// File: rtl/spi_bus_arbiter.sv
// rtl/spi_bus_arbiter.sv - round-robin transaction arbiter sharing one spi_master among requesters
module spi_bus_arbiter #(
    parameter int NUM_CLI = 2,
    parameter int GAP_CYC = 8,
    parameter int TIMEOUT = 65535
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_bus_arbiter_if.slave bus
);
    localparam int IW = (NUM_CLI > 2) ? 2 : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        BUSY = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t               state;
    state_t               state_d;
    logic [IW-1:0]        owner;
    logic [IW-1:0]        owner_d;
    logic [IW-1:0]        ptr;
    logic [IW-1:0]        ptr_d;
    logic [NUM_CLI-1:0]   gnt;
    logic [NUM_CLI-1:0]   gnt_d;
    logic [NUM_CLI-1:0]   mask;
    logic [NUM_CLI-1:0]   mask_d;
    logic [NUM_CLI-1:0]   done;
    logic [NUM_CLI-1:0]   done_d;
    logic [15:0]          wdog;
    logic [15:0]          wdog_d;
    logic [7:0]           gap_cnt;
    logic [7:0]           gap_cnt_d;
    logic [7:0]           rx;
    logic [7:0]           rx_d;
    logic [7:0]           tx;
    logic [7:0]           tx_d;
    logic                 sreq;
    logic                 sreq_d;
    logic                 tmo;
    logic                 tmo_d;

    logic                 found;
    logic [IW-1:0]        pick;
    logic [IW-1:0]        cand;
    logic                 lock_g;
    logic                 req_g;
    logic [7:0]           tx_g;
    logic [IW-1:0]        next_ptr;

    // Current owner's view of the requester inputs
    assign lock_g   = bus.cli_lock[owner];
    assign req_g    = bus.cli_req[owner];
    assign tx_g     = bus.cli_tx[{owner, 3'b000} +: 8];
    assign next_ptr = IW'((int'(owner) + 1) % NUM_CLI);

    // Round-robin search over unmasked lock requests, starting at ptr
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 0; k < NUM_CLI; k++) begin
            cand = IW'((int'(ptr) + k) % NUM_CLI);
            if (!found && bus.cli_lock[cand] && !mask[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Next-state logic and next values of all registered outputs
    always_comb begin
        state_d   = state;
        owner_d   = owner;
        ptr_d     = ptr;
        gnt_d     = gnt;
        mask_d    = mask & bus.cli_lock;
        done_d    = '0;
        rx_d      = rx;
        sreq_d    = 1'b0;
        tx_d      = tx;
        tmo_d     = 1'b0;
        wdog_d    = wdog;
        gap_cnt_d = gap_cnt;
        case (state)
            IDLE: begin
                if (found) begin
                    owner_d      = pick;
                    gnt_d        = '0;
                    gnt_d[pick]  = 1'b1;
                    wdog_d       = '0;
                    state_d      = OWN;
                end
            end
            OWN: begin
                if (!lock_g) begin
                    // Lock drop wins over a same-cycle byte request
                    gnt_d     = '0;
                    ptr_d     = next_ptr;
                    gap_cnt_d = '0;
                    state_d   = GAP;
                end else if (req_g) begin
                    tx_d    = tx_g;
                    sreq_d  = 1'b1;
                    wdog_d  = '0;
                    state_d = BUSY;
                end else if (wdog == 16'(TIMEOUT - 1)) begin
                    // Owner sat idle for TIMEOUT cycles: evict it until it drops lock
                    tmo_d         = 1'b1;
                    gnt_d         = '0;
                    mask_d[owner] = 1'b1;
                    ptr_d         = next_ptr;
                    gap_cnt_d     = '0;
                    state_d       = GAP;
                end else begin
                    wdog_d = wdog + 16'd1;
                end
            end
            BUSY: begin
                if (bus.spi_done) begin
                    // The in-flight byte is always delivered, even after lock drop
                    done_d[owner] = 1'b1;
                    rx_d          = bus.spi_rx;
                    wdog_d        = '0;
                    if (lock_g) begin
                        state_d = OWN;
                    end else begin
                        gnt_d     = '0;
                        ptr_d     = next_ptr;
                        gap_cnt_d = '0;
                        state_d   = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == 8'(GAP_CYC - 1)) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            owner   <= '0;
            ptr     <= '0;
            gnt     <= '0;
            mask    <= '0;
            done    <= '0;
            rx      <= '0;
            sreq    <= 1'b0;
            tx      <= '0;
            tmo     <= 1'b0;
            wdog    <= '0;
            gap_cnt <= '0;
        end else begin
            state   <= state_d;
            owner   <= owner_d;
            ptr     <= ptr_d;
            gnt     <= gnt_d;
            mask    <= mask_d;
            done    <= done_d;
            rx      <= rx_d;
            sreq    <= sreq_d;
            tx      <= tx_d;
            tmo     <= tmo_d;
            wdog    <= wdog_d;
            gap_cnt <= gap_cnt_d;
        end
    end

    assign bus.cli_gnt  = gnt;
    assign bus.cli_done = done;
    assign bus.cli_rx   = rx;
    assign bus.timeout  = tmo;
    assign bus.spi_req  = sreq;
    assign bus.spi_tx   = tx;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// tb/tb_spi_bus_arbiter.sv - self-checking bench for spi_bus_arbiter
module tb_spi_bus_arbiter;
    localparam int N       = 3;
    localparam int GAP_CYC = 4;
    localparam int TIMEOUT = 16;
    localparam int NV      = 11;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    spi_bus_arbiter_if #(.NUM_CLI(N)) bus ();

    spi_bus_arbiter #(
        .NUM_CLI(N),
        .GAP_CYC(GAP_CYC),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]   lock;
        logic [N-1:0]   req;
        logic [8*N-1:0] tx;
        logic           sdone;
        logic [7:0]     srx;
        logic [N-1:0]   gnt;
        logic           sreq;
        logic [7:0]     stx;
        logic [N-1:0]   done;
        logic [7:0]     rx;
        logic           tmo;
    } vec_t;

    vec_t tbl [NV];

    // Reference model: who holds the bus, whether a byte is outstanding,
    // how long the holder has been quiet and how much deselect time remains.
    int           m_owner;
    int           m_last;
    int           m_quiet;
    int           m_gap;
    bit           m_inflight;
    bit [N-1:0]   m_ban;
    logic [N-1:0] e_gnt;
    logic [N-1:0] e_done;
    logic [7:0]   e_rx;
    logic [7:0]   e_stx;
    logic         e_tmo;
    logic         e_sreq;

    function automatic void model_reset();
        m_owner    = -1;
        m_last     = N - 1;
        m_quiet    = 0;
        m_gap      = 0;
        m_inflight = 0;
        m_ban      = '0;
        e_gnt      = '0;
        e_done     = '0;
        e_rx       = '0;
        e_stx      = '0;
        e_tmo      = 1'b0;
        e_sreq     = 1'b0;
    endfunction

    function automatic void model_release();
        m_last  = m_owner;
        m_owner = -1;
        m_gap   = GAP_CYC;
    endfunction

    function automatic void model_step();
        int c;
        e_done = '0;
        e_tmo  = 1'b0;
        e_sreq = 1'b0;
        m_ban  = m_ban & bus.cli_lock;
        if (m_owner < 0) begin
            if (m_gap > 0) begin
                m_gap--;
            end else begin
                for (int k = 0; k < N; k++) begin
                    c = (m_last + 1 + k) % N;
                    if (m_owner < 0 && bus.cli_lock[c] && !m_ban[c]) begin
                        m_owner = c;
                        m_quiet = 0;
                    end
                end
            end
        end else if (m_inflight) begin
            if (bus.spi_done) begin
                e_done[m_owner] = 1'b1;
                e_rx            = bus.spi_rx;
                m_inflight      = 0;
                m_quiet         = 0;
                if (!bus.cli_lock[m_owner]) model_release();
            end
        end else begin
            if (!bus.cli_lock[m_owner]) begin
                model_release();
            end else if (bus.cli_req[m_owner]) begin
                e_sreq     = 1'b1;
                e_stx      = bus.cli_tx[8*m_owner +: 8];
                m_inflight = 1;
                m_quiet    = 0;
            end else begin
                m_quiet++;
                if (m_quiet == TIMEOUT) begin
                    e_tmo          = 1'b1;
                    m_ban[m_owner] = 1'b1;
                    model_release();
                end
            end
        end
        e_gnt = '0;
        if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
    endfunction

    function automatic logic [63:0] pack(input logic [N-1:0] g, input logic [N-1:0] d,
                                         input logic [7:0] r, input logic t,
                                         input logic s, input logic [7:0] x);
        return 64'({g, d, r, t, s, x});
    endfunction

    function automatic logic [63:0] outs();
        return pack(bus.cli_gnt, bus.cli_done, bus.cli_rx, bus.timeout, bus.spi_req, bus.spi_tx);
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = N - 1; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.cli_lock = '0;
        bus.cli_req  = '0;
        bus.cli_tx   = '0;
        bus.spi_done = 1'b0;
        bus.spi_rx   = '0;
        rst_n        = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        int          o;
        int          nb;
        int          wcnt;
        int          zrun;
        bit          pend;
        bit          gap_ok;
        logic [N-1:0] prev_gnt;
        int          order[$];
        logic [15:0] seq;

        errors = 0;
        checks = 0;

        //            lock    req     tx          sd   srx     gnt     sreq stx    done    rx     tmo
        tbl[0]  = '{3'b001, 3'b000, 24'h000000, 1'b1, 8'h33, 3'b001, 1'b0, 8'h00, 3'b000, 8'h00, 1'b0};
        tbl[1]  = '{3'b001, 3'b001, 24'h00009F, 1'b0, 8'h00, 3'b001, 1'b1, 8'h9F, 3'b000, 8'h00, 1'b0};
        tbl[2]  = '{3'b001, 3'b001, 24'h000011, 1'b0, 8'h00, 3'b001, 1'b0, 8'h9F, 3'b000, 8'h00, 1'b0};
        tbl[3]  = '{3'b001, 3'b000, 24'h000000, 1'b0, 8'h00, 3'b001, 1'b0, 8'h9F, 3'b000, 8'h00, 1'b0};
        tbl[4]  = '{3'b001, 3'b000, 24'h000000, 1'b1, 8'hEF, 3'b001, 1'b0, 8'h9F, 3'b001, 8'hEF, 1'b0};
        tbl[5]  = '{3'b000, 3'b000, 24'h000000, 1'b0, 8'h00, 3'b000, 1'b0, 8'h9F, 3'b000, 8'hEF, 1'b0};
        tbl[6]  = '{3'b010, 3'b010, 24'h002200, 1'b1, 8'h55, 3'b000, 1'b0, 8'h9F, 3'b000, 8'hEF, 1'b0};
        tbl[7]  = '{3'b010, 3'b010, 24'h002200, 1'b1, 8'h56, 3'b000, 1'b0, 8'h9F, 3'b000, 8'hEF, 1'b0};
        tbl[8]  = '{3'b010, 3'b000, 24'h000000, 1'b0, 8'h00, 3'b000, 1'b0, 8'h9F, 3'b000, 8'hEF, 1'b0};
        tbl[9]  = '{3'b010, 3'b000, 24'h000000, 1'b0, 8'h00, 3'b000, 1'b0, 8'h9F, 3'b000, 8'hEF, 1'b0};
        tbl[10] = '{3'b011, 3'b000, 24'h000000, 1'b0, 8'h00, 3'b010, 1'b0, 8'h9F, 3'b000, 8'hEF, 1'b0};

        do_reset();
        check("reset_state", outs(), 64'd0);

        // single byte, stray inputs, gap timing, round-robin pointer
        for (int i = 0; i < NV; i++) begin
            bus.cli_lock = tbl[i].lock;
            bus.cli_req  = tbl[i].req;
            bus.cli_tx   = tbl[i].tx;
            bus.spi_done = tbl[i].sdone;
            bus.spi_rx   = tbl[i].srx;
            step();
            check($sformatf("vec%0d", i), outs(),
                  pack(tbl[i].gnt, tbl[i].done, tbl[i].rx, tbl[i].tmo, tbl[i].sreq, tbl[i].stx));
        end

        // watchdog on client1, which holds lock and never requests
        bus.cli_req  = '0;
        bus.spi_done = 1'b0;
        bus.cli_lock = 3'b011;
        repeat (15) step();
        check("wdog_before", 64'({bus.cli_gnt, bus.timeout}), 64'({3'b010, 1'b0}));
        step();
        check("wdog_fire", 64'({bus.cli_gnt, bus.timeout}), 64'({3'b000, 1'b1}));
        step();
        check("wdog_pulse", 64'({bus.cli_gnt, bus.timeout}), 64'd0);
        repeat (3) step();
        check("wdog_gap", 64'(bus.cli_gnt), 64'd0);
        step();
        check("wdog_next_owner", 64'(bus.cli_gnt), 64'(3'b001));
        bus.cli_lock = 3'b010;
        step();
        check("own0_release", 64'(bus.cli_gnt), 64'd0);
        repeat (12) step();
        check("masked_no_regrant", 64'(bus.cli_gnt), 64'd0);
        bus.cli_lock = 3'b000;
        step();
        bus.cli_lock = 3'b010;
        step();
        check("regrant_after_toggle", 64'(bus.cli_gnt), 64'(3'b010));

        // contention: clients 0 and 1, two bytes per transaction
        do_reset();
        bus.cli_lock = 3'b011;
        order.delete();
        zrun = 0; gap_ok = 1; nb = 0; pend = 0; wcnt = 0; prev_gnt = '0;
        for (int cyc = 0; cyc < 400 && order.size() < 4; cyc++) begin
            step();
            bus.cli_req  = '0;
            bus.spi_done = 1'b0;
            o = onehot_idx(bus.cli_gnt);
            if (o < 0) begin
                zrun++;
                bus.cli_lock = 3'b011;
            end else if (prev_gnt == '0) begin
                order.push_back(o);
                if (order.size() > 1 && zrun < GAP_CYC) gap_ok = 0;
                zrun = 0; nb = 0; pend = 0;
            end
            prev_gnt = bus.cli_gnt;
            if (|bus.cli_done) begin
                nb++;
                pend = 0;
            end
            if (bus.spi_req) begin
                wcnt = 3;
            end else if (wcnt > 0) begin
                wcnt--;
                if (wcnt == 0) begin
                    bus.spi_done = 1'b1;
                    bus.spi_rx   = 8'($urandom);
                end
            end
            if (o >= 0) begin
                if (nb == 2) begin
                    bus.cli_lock[o] = 1'b0;
                end else if (!pend) begin
                    bus.cli_req[o]        = 1'b1;
                    bus.cli_tx[8*o +: 8]  = 8'($urandom);
                    pend                  = 1;
                end
            end
        end
        seq = '0;
        foreach (order[i]) seq = (seq << 4) | 16'(order[i]);
        check("rr_grant_count", 64'(order.size()), 64'd4);
        check("rr_order", 64'(seq), 64'h0101);
        check("rr_gap", 64'(gap_ok), 64'd1);

        // lock drop while BUSY
        do_reset();
        bus.cli_lock = 3'b011;
        step();
        check("busy_drop_gnt", 64'(bus.cli_gnt), 64'(3'b001));
        bus.cli_req = 3'b001;
        bus.cli_tx  = 24'h0000A5;
        step();
        check("busy_drop_req", 64'({bus.spi_req, bus.spi_tx}), 64'({1'b1, 8'hA5}));
        bus.cli_req  = '0;
        bus.cli_lock = 3'b010;
        step();
        step();
        check("busy_drop_hold", 64'({bus.cli_gnt, bus.cli_done}), 64'({3'b001, 3'b000}));
        bus.spi_done = 1'b1;
        bus.spi_rx   = 8'h3C;
        step();
        check("busy_drop_done", 64'({bus.cli_gnt, bus.cli_done, bus.cli_rx}),
              64'({3'b000, 3'b001, 8'h3C}));
        bus.spi_done = 1'b0;
        repeat (4) step();
        check("busy_drop_gap", 64'(bus.cli_gnt), 64'd0);
        step();
        check("busy_drop_next", 64'(bus.cli_gnt), 64'(3'b010));

        // asynchronous reset in the middle of a byte
        bus.cli_req = 3'b010;
        bus.cli_tx  = 24'h007700;
        step();
        check("async_req", 64'({bus.spi_req, bus.spi_tx}), 64'({1'b1, 8'h77}));
        bus.cli_req = '0;
        step();
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", outs(), 64'd0);
        bus.cli_lock = '0;
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.spi_done = 1'b1;
        bus.spi_rx   = 8'h99;
        step();
        check("late_spi_done", 64'({bus.cli_done, bus.cli_rx}), 64'd0);
        bus.spi_done = 1'b0;

        // randomized traffic against the reference model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) do_reset();
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 15) == 0) bus.cli_lock[i] = ~bus.cli_lock[i];
                bus.cli_req[i] = (i == 2) ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 2) == 0);
            end
            bus.cli_tx   = 24'($urandom);
            bus.spi_done = ($urandom_range(0, 3) == 0);
            bus.spi_rx   = 8'($urandom);
            step();
            check($sformatf("rand%0d", c), outs(), pack(e_gnt, e_done, e_rx, e_tmo, e_sreq, e_stx));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
